regfile_param: RTL and testbench
================================

Name: regfile_param

Overview:
Parametrised successor to the fixed 32x64 register file: DEPTH = 2^ADDR_W entries of DATA_W bits, two read ports, one write port. Adds registered (1-cycle) reads, an optional hardwired zero register (LEGv8 XZR) and a sequential clear engine that zeroes the array one entry per cycle. Sits in the decode stage of the datapath, feeding ALU operands A/B.

Parameters:
DATA_W, 64, entry width in bits
ADDR_W, 5, address width; DEPTH = 2^ADDR_W
ZERO_REG, 1, 1 = entry DEPTH-1 is hardwired zero; 0 = ordinary register

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
write  input  1  write enable
wrAddr  input  ADDR_W  write address
wrData  input  DATA_W  write data
rdAddrA  input  ADDR_W  read address, port A
rdAddrB  input  ADDR_W  read address, port B
clear  input  1  start bulk clear (sampled in IDLE only)
rdDataA  output  DATA_W  registered read data, port A
rdDataB  output  DATA_W  registered read data, port B
busy  output  1  high while the clear engine runs

Behaviour:
- reset low (async): every entry = 0, rdDataA = rdDataB = 0, busy = 0, state = IDLE, clrPtr = 0. Applies immediately, including mid-clear; the clear is abandoned.
- Write: at posedge, if write=1, state=IDLE and not (ZERO_REG=1 and wrAddr=DEPTH-1), mem[wrAddr] <= wrData.
- Write to zero register: silently dropped. Reads of entry DEPTH-1 always return 0 when ZERO_REG=1.
- Read latency: 1 cycle. At posedge, rdDataX <= mem[rdAddrX] using the pre-edge array contents. Without the optional feature, a same-cycle write to the same address is seen by a read one cycle later.
- Ports A and B are independent. Both may address the same entry.
- States: IDLE, CLEAR.
- IDLE -> CLEAR: at a posedge with clear=1. A write presented on that same edge is still performed. clrPtr <= 0 and busy <= 1.
- CLEAR: on each posedge, mem[clrPtr] <= 0 and clrPtr <= clrPtr+1.
- CLEAR -> IDLE: on the edge that clears entry DEPTH-1. busy <= 0 on that edge. busy is therefore high for exactly DEPTH cycles.
- During CLEAR:
  - write is ignored (dropped, not queued).
  - clear is ignored.
  - Reads continue and return the partially cleared contents.
- clrPtr width is ADDR_W. Termination is detected at clrPtr = DEPTH-1, with no wrap beyond it.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: write-through forwarding. At a posedge, if write=1, the write is accepted (IDLE, not the zero register) and wrAddr = rdAddrX, then rdDataX <= wrData instead of the stale mem value. Each port is independent.
- Undefined: reads always return pre-edge array contents.
- No bypass occurs for dropped writes (zero register, CLEAR state).

Test Plan:
- Reset low, release; read addresses 0..31 with no writes -> rdDataA/B = 0 for every address, busy = 0.
- Write 0xDEADBEEF_00000001 to addr 5; next cycle rdAddrA=5, rdAddrB=5 -> both ports = 0xDEADBEEF_00000001 one cycle after the address is applied.
- Same edge: write addr 7 = 0x1234, rdAddrA = 7 (old value 0) -> rdDataA = 0 without REGFILE_BYPASS_EN; 0x1234 with it.
- ZERO_REG=1: write addr 31 = all-ones, then read 31 -> 0. ZERO_REG=0, same sequence -> 0xFFFF_FFFF_FFFF_FFFF.
- Fill addrs 0..30 with nonzero data, pulse clear with a simultaneous write to addr 3 -> busy high for exactly 32 cycles. Writes issued during busy are dropped. Afterwards every entry reads 0.
- Start clear, assert reset low after 10 cycles -> busy = 0 and outputs = 0 immediately. After release, all entries read 0 and a new write/read works normally.

Source files
------------

// File: rtl/regfile_param.sv
// Parametrised 2R1W register file with registered reads, optional hardwired zero
// register and a one-entry-per-cycle clear engine. Optional write-through: REGFILE_BYPASS_EN.
module regfile_param #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic [ADDR_W-1:0] rdAddrA,
    input  logic [ADDR_W-1:0] rdAddrB,
    input  logic              clear,
    output logic [DATA_W-1:0] rdDataA,
    output logic [DATA_W-1:0] rdDataB,
    output logic              busy
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              zero_wr;
    logic              wr_ok;
    logic [DATA_W-1:0] next_a;
    logic [DATA_W-1:0] next_b;

    // Writes to the zero register and writes during a clear are dropped outright.
    assign zero_wr = (ZERO_REG != 0) && (wrAddr == LAST);
    assign wr_ok   = write && (state == IDLE) && !zero_wr;

    always_comb begin
        next_a = mem[rdAddrA];
        next_b = mem[rdAddrB];
        if ((ZERO_REG != 0) && (rdAddrA == LAST)) next_a = '0;
        if ((ZERO_REG != 0) && (rdAddrB == LAST)) next_b = '0;
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (wrAddr == rdAddrA)) next_a = wrData;
        if (wr_ok && (wrAddr == rdAddrB)) next_b = wrData;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rdDataA <= '0;
            rdDataB <= '0;
            busy    <= 1'b0;
            state   <= IDLE;
            clr_ptr <= '0;
        end else begin
            rdDataA <= next_a;
            rdDataB <= next_b;
            case (state)
                IDLE: begin
                    if (wr_ok) mem[wrAddr] <= wrData;
                    if (clear) begin
                        state   <= CLEAR;
                        clr_ptr <= '0;
                        busy    <= 1'b1;
                    end
                end
                CLEAR: begin
                    mem[clr_ptr] <= '0;
                    // Stop on the last entry rather than wrapping the pointer.
                    if (clr_ptr == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: drives a ZERO_REG=1 and a ZERO_REG=0 instance in lockstep and
// checks both against an array-based reference model every cycle.
module tb_regfile_param;
    localparam int DW    = 64;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

`ifdef REGFILE_BYPASS_EN
    localparam logic [DW-1:0] SAME_EDGE_EXP = 64'h1234;
`else
    localparam logic [DW-1:0] SAME_EDGE_EXP = 64'h0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          write = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [AW-1:0] rd_addr_a = '0;
    logic [AW-1:0] rd_addr_b = '0;
    logic          clear = 1'b0;

    logic [DW-1:0] rd_a [2];
    logic [DW-1:0] rd_b [2];
    logic          busy [2];

    // Index 0: ZERO_REG=1, index 1: ZERO_REG=0
    regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) u_z (
        .clk(clk), .reset(reset), .write(write), .wrAddr(wr_addr), .wrData(wr_data),
        .rdAddrA(rd_addr_a), .rdAddrB(rd_addr_b), .clear(clear),
        .rdDataA(rd_a[0]), .rdDataB(rd_b[0]), .busy(busy[0])
    );

    regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) u_n (
        .clk(clk), .reset(reset), .write(write), .wrAddr(wr_addr), .wrData(wr_data),
        .rdAddrA(rd_addr_a), .rdAddrB(rd_addr_b), .clear(clear),
        .rdDataA(rd_a[1]), .rdDataB(rd_b[1]), .busy(busy[1])
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: plain arrays plus a countdown of remaining clear cycles
    logic [DW-1:0] mm [2][DEPTH];
    logic [DW-1:0] exp_a [2];
    logic [DW-1:0] exp_b [2];
    int            clear_left;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int z = 0; z < 2; z++) begin
                for (int i = 0; i < DEPTH; i++) mm[z][i] = '0;
                exp_a[z] = '0;
                exp_b[z] = '0;
            end
            clear_left = 0;
        end else begin
            for (int z = 0; z < 2; z++) begin
                bit zr;
                bit accept;
                zr     = (z == 0);
                accept = write && (clear_left == 0) && !(zr && wr_addr == AW'(DEPTH - 1));
                exp_a[z] = (zr && rd_addr_a == AW'(DEPTH - 1)) ? '0 : mm[z][rd_addr_a];
                exp_b[z] = (zr && rd_addr_b == AW'(DEPTH - 1)) ? '0 : mm[z][rd_addr_b];
`ifdef REGFILE_BYPASS_EN
                if (accept && wr_addr == rd_addr_a) exp_a[z] = wr_data;
                if (accept && wr_addr == rd_addr_b) exp_b[z] = wr_data;
`endif
                if (clear_left > 0) mm[z][DEPTH - clear_left] = '0;
                else if (accept) mm[z][wr_addr] = wr_data;
            end
            if (clear_left > 0) clear_left = clear_left - 1;
            else if (clear) clear_left = DEPTH;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("z_rdA", rd_a[0], exp_a[0]);
            check("z_rdB", rd_b[0], exp_b[0]);
            check("z_busy", {63'd0, busy[0]}, {63'd0, clear_left > 0});
            check("n_rdA", rd_a[1], exp_a[1]);
            check("n_rdB", rd_b[1], exp_b[1]);
            check("n_busy", {63'd0, busy[1]}, {63'd0, clear_left > 0});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int a, input logic [DW-1:0] d);
        write   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        step();
        write = 1'b0;
    endtask

    task automatic read_sweep();
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr_a = AW'(i);
            rd_addr_b = AW'(DEPTH - 1 - i);
            step();
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy[0] && n < 40) begin
            step();
            n++;
        end
        check(name, {63'd0, busy[0]}, 64'd0);
    endtask

    initial begin
        int cnt;
        repeat (3) step();
        reset  = 1'b1;
        chk_en = 1'b1;
        step();

        // Empty array after reset
        read_sweep();
        check("reset_rdA", rd_a[0], 64'd0);
        check("reset_busy", {63'd0, busy[0]}, 64'd0);

        // Basic write then read on both ports
        do_write(5, 64'hDEADBEEF_00000001);
        rd_addr_a = 5;
        rd_addr_b = 5;
        step();
        check("wr5_rdA", rd_a[0], 64'hDEADBEEF_00000001);
        check("wr5_rdB", rd_b[0], 64'hDEADBEEF_00000001);

        // Same-edge write and read of one address
        rd_addr_a = 7;
        do_write(7, 64'h1234);
        check("same_edge_rdA", rd_a[0], SAME_EDGE_EXP);
        step();
        check("after_edge_rdA", rd_a[0], 64'h1234);

        // Zero register
        do_write(31, '1);
        rd_addr_a = 31;
        rd_addr_b = 31;
        step();
        check("xzr_z", rd_a[0], 64'd0);
        check("xzr_n", rd_a[1], 64'hFFFF_FFFF_FFFF_FFFF);

        // Randomized traffic with occasional clears
        for (int k = 0; k < 400; k++) begin
            write     = ($urandom_range(0, 2) != 0);
            wr_addr   = AW'($urandom_range(0, DEPTH - 1));
            wr_data   = {$urandom, $urandom};
            rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, DEPTH - 1));
            rd_addr_b = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, DEPTH - 1));
            clear     = ($urandom_range(0, 99) == 0);
            step();
        end
        write = 1'b0;
        clear = 1'b0;
        wait_idle("rand_idle");

        // Fill, then clear with a simultaneous write; count busy cycles
        for (int i = 0; i < DEPTH - 1; i++) do_write(i, {32'hA5A5_0000 + 32'(i), 32'h1 + 32'(i)});
        clear   = 1'b1;
        do_write(3, 64'hCAFE);
        clear = 1'b0;
        cnt = 0;
        while (busy[0] && cnt < 40) begin
            write     = 1'b1;
            wr_addr   = AW'($urandom_range(0, DEPTH - 1));
            wr_data   = {$urandom, $urandom};
            rd_addr_a = AW'($urandom_range(0, DEPTH - 1));
            rd_addr_b = 3;
            clear     = $urandom_range(0, 1) == 1;
            cnt++;
            step();
        end
        write = 1'b0;
        clear = 1'b0;
        check("busy_cycles", 64'(cnt), 64'd32);
        read_sweep();
        rd_addr_a = 3;
        step();
        check("cleared_3", rd_a[1], 64'd0);

        // Reset in the middle of a clear
        for (int i = 0; i < 8; i++) do_write(i, 64'h77 + 64'(i));
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (10) step();
        check("mid_busy_before", {63'd0, busy[0]}, 64'd1);
        reset = 1'b0;
        #1;
        check("mid_busy", {63'd0, busy[0]}, 64'd0);
        check("mid_rdA", rd_a[0], 64'd0);
        check("mid_rdB", rd_b[1], 64'd0);
        step();
        reset = 1'b1;
        step();
        read_sweep();
        do_write(12, 64'h0123_4567_89AB_CDEF);
        rd_addr_a = 12;
        step();
        check("post_reset_wr", rd_a[1], 64'h0123_4567_89AB_CDEF);
        step();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
